// File: rtl/pic_pkg.sv
// Shared types and helpers for the PIC interrupt sequencer.
// Priority rotation is done on a 16-bit container.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2
    } pic_state_e;

    localparam int MIN_IRQ = 2;
    localparam int MAX_IRQ = 16;

    typedef logic [MAX_IRQ-1:0] irq_vec_t;

    function automatic bit num_irq_legal(int n);
        return (n >= MIN_IRQ) && (n <= MAX_IRQ);
    endfunction

    // Bit i of the result is bit (i+amt) mod n of v.
    function automatic irq_vec_t rotate_right(irq_vec_t v, int n, int amt);
        irq_vec_t r;
        int k;
        r = '0;
        for (int i = 0; i < MAX_IRQ; i++) begin
            if (i < n) begin
                k = i + amt;
                if (k >= n) k = k - n;
                r[i[3:0]] = v[k[3:0]];
            end
        end
        return r;
    endfunction

    function automatic irq_vec_t rotate_left(irq_vec_t v, int n, int amt);
        irq_vec_t r;
        int k;
        r = '0;
        for (int i = 0; i < MAX_IRQ; i++) begin
            if (i < n) begin
                k = i + amt;
                if (k >= n) k = k - n;
                r[k[3:0]] = v[i[3:0]];
            end
        end
        return r;
    endfunction

    function automatic logic [3:0] priority_encode(irq_vec_t v);
        logic [3:0] p;
        p = '0;
        for (int i = MAX_IRQ - 1; i >= 0; i--) begin
            if (v[i[3:0]]) p = i[3:0];
        end
        return p;
    endfunction

    // 0 = highest priority, n-1 = lowest
    function automatic int prio_rank(int lvl, int lp, int n);
        int k;
        k = lvl + n - lp - 1;
        if (k >= n) k = k - n;
        return k;
    endfunction

endpackage

// File: rtl/pic_irq_sequencer_if.sv
// CPU-side bus of the PIC sequencer: INTA/poll in, INT and vector out.
// master = CPU / bus buffer side, slave = sequencer side.
interface pic_irq_sequencer_if #(
    parameter int VEC_W = 8
);
    logic             INTA_n;
    logic             poll_req;
    logic             INT;
    logic [VEC_W-1:0] data_out;
    logic             data_out_valid;

    modport master (
        output INTA_n, poll_req,
        input  INT, data_out, data_out_valid
    );

    modport slave (
        input  INTA_n, poll_req,
        output INT, data_out, data_out_valid
    );
endinterface

// File: rtl/pic_priority_resolver.sv
// Combinational rotating-priority resolver: highest priority
// level is lowest+1 (mod NUM_IRQ), descending with wrap.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    localparam int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   lowest,
    output logic [IDX_W-1:0]   idx,
    output logic               found
);

    int       top_lvl;
    int       pos;
    irq_vec_t rot;

    always_comb begin
        top_lvl = int'(lowest) + 1;
        if (top_lvl >= NUM_IRQ) top_lvl = 0;
        rot = rotate_right(irq_vec_t'(req), NUM_IRQ, top_lvl);
        pos = int'(priority_encode(rot)) + top_lvl;
        if (pos >= NUM_IRQ) pos = pos - NUM_IRQ;
        found = |req;
        idx   = found ? IDX_W'(pos) : '0;
    end

endmodule

// File: rtl/pic_irq_sequencer.sv
// PIC priority/INTA sequencer: ISR, EOI/AEOI, rotation, vector.
// Optional poll command path: define PIC_POLL_MODE_EN.
module pic_irq_sequencer
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ = 8,
    parameter  int VEC_W   = 8,
    localparam int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               init,
    input  logic [NUM_IRQ-1:0] irr,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [VEC_W-1:0]   vector_base,
    input  logic               aeoi,
    input  logic               rotate_on_aeoi,
    input  logic               eoi_valid,
    input  logic               eoi_specific,
    input  logic               eoi_rotate,
    input  logic [IDX_W-1:0]   eoi_level,
    input  logic               set_pri_valid,
    input  logic [IDX_W-1:0]   set_pri_level,
    pic_irq_sequencer_if.slave bus,
    output logic [NUM_IRQ-1:0] clear_irr,
    output logic [NUM_IRQ-1:0] isr,
    output logic [IDX_W-1:0]   lowest_priority
);

    if (!num_irq_legal(NUM_IRQ) || VEC_W <= IDX_W) begin : g_bad_cfg
        $error("pic_irq_sequencer: illegal NUM_IRQ or VEC_W");
    end

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_IRQ - 1);

    pic_state_e         state_q, state_n;
    logic               prev_inta_q;
    logic               inta_fall, inta_rise;
    logic [IDX_W-1:0]   ack_q, ack_d;
    logic               spur_q, spur_d;
    logic [IDX_W-1:0]   w_idx, s_idx;
    logic               w_found, s_found;
    logic               int_q, int_d, int_cond;
    logic [VEC_W-1:0]   dout_q, dout_d;
    logic               dv_q, dv_d;
    logic [NUM_IRQ-1:0] isr_q, isr_d, clr_q;
    logic [NUM_IRQ-1:0] set_m, clr_m;
    logic [IDX_W-1:0]   lp_q, lp_d;
    logic               eoi_hit, aeoi_rot;
    logic [IDX_W-1:0]   eoi_lvl;
    logic               unused_bits;

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_req_res (
        .req    (irr & ~imr),
        .lowest (lp_q),
        .idx    (w_idx),
        .found  (w_found)
    );

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ)) u_isr_res (
        .req    (isr_q),
        .lowest (lp_q),
        .idx    (s_idx),
        .found  (s_found)
    );

    assign inta_fall = prev_inta_q & ~bus.INTA_n;
    assign inta_rise = ~prev_inta_q & bus.INTA_n;

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            prev_inta_q <= 1'b1;
            ack_q       <= '0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            dout_q      <= '0;
            dv_q        <= 1'b0;
            clr_q       <= '0;
            isr_q       <= '0;
            lp_q        <= LAST;
        end else if (init) begin
            state_q     <= IDLE;
            prev_inta_q <= 1'b1;
            ack_q       <= '0;
            spur_q      <= 1'b0;
            int_q       <= 1'b0;
            dout_q      <= '0;
            dv_q        <= 1'b0;
            clr_q       <= '0;
            isr_q       <= '0;
            lp_q        <= LAST;
        end else begin
            state_q     <= state_n;
            prev_inta_q <= bus.INTA_n;
            ack_q       <= ack_d;
            spur_q      <= spur_d;
            int_q       <= int_d;
            dout_q      <= dout_d;
            dv_q        <= dv_d;
            clr_q       <= set_m;
            isr_q       <= isr_d;
            lp_q        <= lp_d;
        end
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE:    if (inta_fall) state_n = ACK1;
            ACK1:    if (inta_rise) state_n = ACK2;
            ACK2:    if (inta_rise) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        ack_d    = ack_q;
        spur_d   = spur_q;
        set_m    = '0;
        clr_m    = '0;
        dout_d   = '0;
        dv_d     = 1'b0;
        lp_d     = lp_q;
        eoi_hit  = 1'b0;
        eoi_lvl  = '0;
        aeoi_rot = 1'b0;

        if (state_q == IDLE && inta_fall) begin
            ack_d  = w_found ? w_idx : LAST;
            spur_d = ~w_found;
            if (w_found) set_m[w_idx] = 1'b1;
        end
`ifdef PIC_POLL_MODE_EN
        else if (state_q == IDLE && bus.poll_req) begin
            dv_d            = 1'b1;
            dout_d          = VEC_W'(w_idx);
            dout_d[VEC_W-1] = w_found;
            if (w_found) set_m[w_idx] = 1'b1;
        end
`endif

        if (state_q == ACK2) begin
            if (inta_rise) begin
                if (aeoi && !spur_q) begin
                    clr_m[ack_q] = 1'b1;
                    aeoi_rot     = rotate_on_aeoi;
                end
            end else if (!bus.INTA_n) begin
                dv_d   = 1'b1;
                dout_d = {vector_base[VEC_W-1:IDX_W], ack_q};
            end
        end

        if (eoi_valid) begin
            if (eoi_specific) begin
                if (int'(eoi_level) < NUM_IRQ) begin
                    eoi_hit = 1'b1;
                    eoi_lvl = eoi_level;
                end
            end else if (s_found) begin
                eoi_hit = 1'b1;
                eoi_lvl = s_idx;
            end
        end
        if (eoi_hit) clr_m[eoi_lvl] = 1'b1;

        if (set_pri_valid && int'(set_pri_level) < NUM_IRQ)
            lp_d = set_pri_level;
        else if (eoi_hit && eoi_rotate)
            lp_d = eoi_lvl;
        else if (aeoi_rot)
            lp_d = ack_q;

        // A same-edge set beats any clear of that bit
        isr_d = (isr_q & ~clr_m) | set_m;

        int_cond = w_found && (!s_found ||
            prio_rank(int'(w_idx), int'(lp_q), NUM_IRQ) <
            prio_rank(int'(s_idx), int'(lp_q), NUM_IRQ));
        int_d = (state_n == IDLE) && int_cond;
    end

`ifdef PIC_POLL_MODE_EN
    assign unused_bits = ^vector_base[IDX_W-1:0];
`else
    assign unused_bits = ^{vector_base[IDX_W-1:0], bus.poll_req};
`endif

    assign bus.INT            = int_q;
    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dv_q;
    assign clear_irr          = clr_q;
    assign isr                = isr_q;
    assign lowest_priority    = lp_q;

endmodule
